// File: rtl/riscv_v_rf_mp.sv
// riscv_v_rf_mp - RISC-V V-extension vector register file.
//
// NUM_REGS x DATA_W storage with one byte-enabled write port and NUM_RD_PORTS
// combinational read ports. After reset, and on i_clr_req, a clear sequencer
// zeroes every register one per cycle. While it runs, reads and mask return 0
// and writes are ignored.
//
// Optional feature macro: RISCV_V_RF_BYPASS_EN
//   defined   : a read port whose address matches i_wr_addr returns the
//               enabled write bytes in the same cycle (mask is never bypassed)
//   undefined : reads always return stored contents
//
// Ports
//   i_clk        clock, all state on rising edge
//   i_rst_n      async active-low reset (FSM, clear counter, ready flag only)
//   i_clr_req    start a full-file clear (honoured only when ready)
//   o_rf_ready   1 = clear finished, reads valid, writes accepted
//   i_wr_addr    write register index
//   i_wr_en      per-byte write enable
//   i_wr_data    write data
//   i_rd_addr    packed read addresses, port p at [p*AW +: AW]
//   o_rd_data    packed read data, port p at [p*DATA_W +: DATA_W]
//   o_mask       stored regs[MASK_REG][MASK_W-1:0]
//   i_syn_addr   observation address
//   o_syn_data   regs[i_syn_addr], raw storage, never bypassed or forced
//
// State table
//   S_CLEAR | zeroing regs[r_clr_cnt], one register per cycle; reads forced to 0
//   S_READY | normal operation: writes accepted, reads valid

module riscv_v_rf_mp #(
    parameter int  NUM_REGS     = 32,
    parameter int  DATA_W       = 128,
    parameter int  NUM_RD_PORTS = 3,
    parameter int  MASK_REG     = 0,
    parameter int  MASK_W       = 16,
    localparam int AW           = $clog2(NUM_REGS),
    localparam int NB           = DATA_W / 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_clr_req,
    output logic                           o_rf_ready,
    input  logic [AW-1:0]                  i_wr_addr,
    input  logic [NB-1:0]                  i_wr_en,
    input  logic [DATA_W-1:0]              i_wr_data,
    input  logic [NUM_RD_PORTS*AW-1:0]     i_rd_addr,
    output logic [NUM_RD_PORTS*DATA_W-1:0] o_rd_data,
    output logic [MASK_W-1:0]              o_mask,
    input  logic [AW-1:0]                  i_syn_addr,
    output logic [DATA_W-1:0]              o_syn_data
);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    localparam logic [AW-1:0] LAST_REG = AW'(NUM_REGS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic [AW-1:0]   w_clr_cnt_nxt;
    logic            r_rf_ready;
    logic            w_rf_ready_nxt;

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_CLEAR;
            r_clr_cnt  <= '0;
            r_rf_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_rf_ready <= w_rf_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_cnt_nxt  = r_clr_cnt;
        w_rf_ready_nxt = r_rf_ready;
        case (r_state)
            S_CLEAR: begin
                // clr_req is deliberately not looked at here: no restart mid-clear
                w_clr_cnt_nxt = r_clr_cnt + AW'(1);
                if (r_clr_cnt == LAST_REG) begin
                    w_state_nxt    = S_READY;
                    w_clr_cnt_nxt  = '0;
                    w_rf_ready_nxt = 1'b1;
                end
            end
            S_READY: begin
                if (i_clr_req) begin
                    w_state_nxt    = S_CLEAR;
                    w_clr_cnt_nxt  = '0;
                    w_rf_ready_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt    = S_CLEAR;
                w_clr_cnt_nxt  = '0;
                w_rf_ready_nxt = 1'b0;
            end
        endcase
    end

    // Storage has no reset; the clear sequencer is what makes contents defined.
    // A write in the cycle clr_req is taken still lands; the clear overwrites it later.
    always_ff @(posedge i_clk) begin
        if (r_state == S_CLEAR) begin
            r_regs[r_clr_cnt] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (i_wr_en[b]) begin
                    r_regs[i_wr_addr][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [AW-1:0]     w_addr;
        logic [DATA_W-1:0] w_word;

        assign w_addr = i_rd_addr[p*AW +: AW];

`ifdef RISCV_V_RF_BYPASS_EN
        always_comb begin
            w_word = r_regs[w_addr];
            if (w_addr == i_wr_addr) begin
                for (int b = 0; b < NB; b++) begin
                    if (i_wr_en[b]) begin
                        w_word[b*8 +: 8] = i_wr_data[b*8 +: 8];
                    end
                end
            end
        end
`else
        assign w_word = r_regs[w_addr];
`endif

        // The ready gate also suppresses the bypass while clearing.
        assign o_rd_data[p*DATA_W +: DATA_W] = r_rf_ready ? w_word : '0;
    end

    assign o_mask     = r_rf_ready ? r_regs[MASK_REG][MASK_W-1:0] : '0;
    assign o_syn_data = r_regs[i_syn_addr];
    assign o_rf_ready = r_rf_ready;

endmodule

// File: tb/tb_riscv_v_rf_mp.sv
module tb_riscv_v_rf_mp;

    localparam int NR = 32;
    localparam int DW = 128;
    localparam int NP = 3;
    localparam int AW = 5;
    localparam int NB = 16;
    localparam int MW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr_req;
    logic              rf_ready;
    logic [AW-1:0]     wr_addr;
    logic [NB-1:0]     wr_en;
    logic [DW-1:0]     wr_data;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*DW-1:0]  rd_data;
    logic [MW-1:0]     mask;
    logic [AW-1:0]     syn_addr;
    logic [DW-1:0]     syn_data;

    int checks = 0;
    int errors = 0;

    riscv_v_rf_mp #(
        .NUM_REGS(NR), .DATA_W(DW), .NUM_RD_PORTS(NP), .MASK_REG(0), .MASK_W(MW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr_req(clr_req), .o_rf_ready(rf_ready),
        .i_wr_addr(wr_addr), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_mask(mask),
        .i_syn_addr(syn_addr), .o_syn_data(syn_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] port(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    // Drive a write at a negedge, let one rising edge take it, then release.
    task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] en, input logic [DW-1:0] d);
        wr_addr = a; wr_en = en; wr_data = d;
        @(negedge clk);
        wr_en = '0;
        #1;
    endtask

    task automatic peek(input logic [AW-1:0] a, output logic [DW-1:0] d);
        syn_addr = a;
        #1;
        d = syn_data;
    endtask

    // Counts sampled cycles with rf_ready low, starting at the current sample point.
    // Also verifies all read ports and mask stay 0; optionally pulses clr_req mid-way.
    task automatic count_clear(input int kick_at, output int cnt, output logic leak);
        cnt = 0;
        leak = 1'b0;
        while (!rf_ready && cnt < 100) begin
            rd_addr = NP*AW'($urandom);
            #1;
            if (rd_data !== '0 || mask !== '0) leak = 1'b1;
            clr_req = (cnt == kick_at);
            cnt++;
            @(negedge clk);
            #1;
        end
        clr_req = 1'b0;
    endtask

    initial begin
        int            n;
        logic          leak;
        logic [DW-1:0] v;
        logic [DW-1:0] acc;

        rst_n = 1'b0; clr_req = 1'b0; wr_addr = '0; wr_en = '0; wr_data = '0;
        rd_addr = '0; syn_addr = '0;

        // 1: reset and initial clear
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", {127'b0, rf_ready}, 128'd0);
        check("reset_rd", port(0), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        count_clear(-1, n, leak);
        check("clear_len", DW'(n), 128'd32);
        check("clear_rd_zero", {127'b0, leak}, 128'd0);
        check("ready_after_clear", {127'b0, rf_ready}, 128'd1);
        acc = '0;
        for (int i = 0; i < NR; i++) begin
            peek(AW'(i), v);
            acc |= v;
        end
        check("all_regs_zero", acc, 128'd0);

        // 2: byte write
        wr(5'd5, 16'h00F0, {16{8'hAA}});
        peek(5'd5, v);
        check("byte_wr_r5", v, 128'h0000_0000_0000_0000_AAAA_AAAA_0000_0000);
        peek(5'd4, v);
        check("byte_wr_r4", v, 128'd0);
        peek(5'd6, v);
        check("byte_wr_r6", v, 128'd0);
        wr(5'd5, 16'h0000, {16{8'h55}});
        peek(5'd5, v);
        check("no_en_hold_r5", v, 128'h0000_0000_0000_0000_AAAA_AAAA_0000_0000);

        // 3: multi-port reads
        wr(5'd1, 16'hFFFF, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        wr(5'd2, 16'hFFFF, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
        wr(5'd3, 16'hFFFF, 128'h0F0F_0F0F_A5A5_A5A5_5A5A_5A5A_F0F0_F0F0);
        rd_addr = {5'd3, 5'd2, 5'd1};
        #1;
        check("mp_p0_r1", port(0), 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        check("mp_p1_r2", port(1), 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
        check("mp_p2_r3", port(2), 128'h0F0F_0F0F_A5A5_A5A5_5A5A_5A5A_F0F0_F0F0);
        rd_addr = {5'd1, 5'd1, 5'd1};
        #1;
        check("mp_same_p0", port(0), 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        check("mp_same_p1", port(1), 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        check("mp_same_p2", port(2), 128'h1111_2222_3333_4444_5555_6666_7777_8888);

        // 4: bypass / write visibility, mask latency
        rd_addr = {5'd2, 5'd5, 5'd7};
        wr_addr = 5'd7; wr_en = 16'h0001; wr_data = {{15{8'hFF}}, 8'h5C};
        #1;
`ifdef RISCV_V_RF_BYPASS_EN
        check("bypass_same_cycle", port(0), 128'h5C);
`else
        check("no_bypass_old", port(0), 128'h0);
`endif
        check("bypass_other_port", port(1), 128'h0000_0000_0000_0000_AAAA_AAAA_0000_0000);
        @(negedge clk);
        wr_en = '0;
        #1;
        check("wr_visible_next", port(0), 128'h5C);
        wr_addr = 5'd0; wr_en = 16'h0003; wr_data = 128'hBEEF;
        #1;
        check("mask_not_bypassed", DW'(mask), 128'h0);
        @(negedge clk);
        wr_en = '0;
        #1;
        check("mask_updated", DW'(mask), 128'hBEEF);

        // 5: clear request with simultaneous write, second request mid-clear
        clr_req = 1'b1;
        wr_addr = 5'd9; wr_en = 16'hFFFF; wr_data = {16{8'h99}};
        @(negedge clk);
        clr_req = 1'b0; wr_en = '0;
        #1;
        check("clr_ready_low", {127'b0, rf_ready}, 128'd0);
        peek(5'd9, v);
        check("clr_cycle_write_done", v, {16{8'h99}});
        count_clear(10, n, leak);
        check("clr_len", DW'(n), 128'd32);
        check("clr_rd_zero", {127'b0, leak}, 128'd0);
        peek(5'd9, v);
        check("clr_r9_zero", v, 128'd0);
        peek(5'd1, v);
        check("clr_r1_zero", v, 128'd0);
        check("clr_mask_zero", DW'(mask), 128'd0);

        // 6: reset mid-clear restarts the sequence
        wr(5'd20, 16'hFFFF, 128'h2020_2020_2020_2020_2020_2020_2020_2020);
        wr(5'd3, 16'hFFFF, 128'h3333);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("rst_mid_ready", {127'b0, rf_ready}, 128'd0);
        peek(5'd20, v);
        check("rst_mid_r20_held", v, 128'h2020_2020_2020_2020_2020_2020_2020_2020);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        count_clear(-1, n, leak);
        check("rst_restart_len", DW'(n), 128'd32);
        peek(5'd20, v);
        check("rst_r20_zero", v, 128'd0);
        peek(5'd3, v);
        check("rst_r3_zero", v, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
